// File: rtl/sms4_round_core_if.sv
// sms4_round_core_if: block-in / block-out handshake bundle of the SMS4 round core.
// master = block producer/consumer side, slave = the round core.
interface sms4_round_core_if;
  logic [127:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         dec;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;

  modport master (
    output din, din_valid, dec, dout_ready,
    input  din_ready, dout, dout_valid, busy
  );

  modport slave (
    input  din, din_valid, dec, dout_ready,
    output din_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/sms4_round_core.sv
// sms4_round_core: iterative SMS4 data path, one round per clock, 32 rounds per block.
// Drives the downstream-facing controls of the round-key expansion block and consumes
// the round key it registers each cycle.
// Optional feature macro: SMS4_DEC_EN (decrypt: WIND state + reverse key order).
module sms4_round_core (
  input  logic             clk,
  input  logic             reset,
  sms4_round_core_if.slave bus,
  output logic             ks_get_key,
  output logic             ks_exp_run,
  output logic             ks_mode,
  output logic [4:0]       ks_counter,
  input  logic [31:0]      round_key
);

  // SMS4 S-box, byte 0x00 in the top 8 bits.
  localparam logic [2047:0] SBOX_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WIND, ST_RUN, ST_DONE} state_t;

  state_t      state_reg;
  logic [31:0] s0_reg, s1_reg, s2_reg, s3_reg;
  logic [5:0]  rcnt_reg;
  logic        din_ready_reg, dout_valid_reg, busy_reg;
  logic        ks_get_key_reg, ks_exp_run_reg, ks_mode_reg;
  logic [4:0]  ks_counter_reg;
  logic        dec_active;

`ifdef SMS4_DEC_EN
  logic       dec_reg;
  logic [4:0] wcnt_reg;
  assign dec_active = dec_reg;
`else
  assign dec_active = 1'b0;
`endif

  // Byte offset of entry x is (255 - x) * 8, i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  // Round function: Xnew = S0 ^ L(tau(S1 ^ S2 ^ S3 ^ rk)).
  logic [31:0] mix_word, sub_word, lin_word, x_new;
  assign mix_word = s1_reg ^ s2_reg ^ s3_reg ^ round_key;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_word[gi*8 +: 8] = sbox(mix_word[gi*8 +: 8]);
    end
  endgenerate

  assign lin_word = sub_word
                  ^ {sub_word[29:0], sub_word[31:30]}
                  ^ {sub_word[21:0], sub_word[31:22]}
                  ^ {sub_word[13:0], sub_word[31:14]}
                  ^ {sub_word[7:0],  sub_word[31:8]};
  assign x_new = s0_reg ^ lin_word;

  // Key index requested for the next RUN cycle; decrypt walks it downwards (31 - n == ~n).
  logic [4:0] run_next_idx;
  assign run_next_idx = rcnt_reg[4:0] + 5'd1;

  // Control FSM, data registers and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      s0_reg         <= '0;
      s1_reg         <= '0;
      s2_reg         <= '0;
      s3_reg         <= '0;
      rcnt_reg       <= '0;
      din_ready_reg  <= 1'b1;
      dout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      ks_get_key_reg <= 1'b0;
      ks_exp_run_reg <= 1'b0;
      ks_mode_reg    <= 1'b1;
      ks_counter_reg <= '0;
`ifdef SMS4_DEC_EN
      dec_reg        <= 1'b0;
      wcnt_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.din_valid) begin
            {s0_reg, s1_reg, s2_reg, s3_reg} <= bus.din;
`ifdef SMS4_DEC_EN
            dec_reg <= bus.dec;
`endif
            state_reg      <= ST_LOAD;
            din_ready_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            ks_get_key_reg <= 1'b1;
          end
        end
        ST_LOAD: begin
          ks_get_key_reg <= 1'b0;
          ks_exp_run_reg <= 1'b1;
          ks_mode_reg    <= 1'b1;
          ks_counter_reg <= 5'd0;
          rcnt_reg       <= 6'd0;
`ifdef SMS4_DEC_EN
          wcnt_reg  <= 5'd0;
          state_reg <= dec_reg ? ST_WIND : ST_RUN;
`else
          state_reg <= ST_RUN;
`endif
        end
`ifdef SMS4_DEC_EN
        ST_WIND: begin
          // Forward-expand to the last key, then request keys back in reverse order.
          if (wcnt_reg == 5'd31) begin
            state_reg      <= ST_RUN;
            ks_mode_reg    <= 1'b0;
            ks_counter_reg <= 5'd31;
          end else begin
            wcnt_reg       <= wcnt_reg + 5'd1;
            ks_counter_reg <= wcnt_reg + 5'd1;
          end
        end
`endif
        ST_RUN: begin
          // round_key lags the request by one cycle, so rcnt 0 only primes the key block.
          if (rcnt_reg != 6'd0)
            {s0_reg, s1_reg, s2_reg, s3_reg} <= {s1_reg, s2_reg, s3_reg, x_new};
          if (rcnt_reg == 6'd32) begin
            state_reg      <= ST_DONE;
            dout_valid_reg <= 1'b1;
          end else begin
            rcnt_reg <= rcnt_reg + 6'd1;
          end
          if (rcnt_reg < 6'd31) begin
            ks_exp_run_reg <= 1'b1;
            ks_mode_reg    <= ~dec_active;
            ks_counter_reg <= dec_active ? ~run_next_idx : run_next_idx;
          end else begin
            ks_exp_run_reg <= 1'b0;
            ks_mode_reg    <= 1'b1;
            ks_counter_reg <= 5'd0;
          end
        end
        ST_DONE: begin
          if (bus.dout_ready) begin
            state_reg      <= ST_IDLE;
            dout_valid_reg <= 1'b0;
            din_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.din_ready  = din_ready_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.dout       = {s3_reg, s2_reg, s1_reg, s0_reg};
  assign ks_get_key     = ks_get_key_reg;
  assign ks_exp_run     = ks_exp_run_reg;
  assign ks_mode        = ks_mode_reg;
  assign ks_counter     = ks_counter_reg;

endmodule

// File: tb/tb_sms4_round_core.sv
// tb_sms4_round_core: table-driven + randomized bench for sms4_round_core, with a
// behavioural round-key expansion block and a whole-cipher SMS4 reference model.
module tb_sms4_round_core;

  localparam logic [2047:0] SBOX_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  localparam logic [127:0] FK_ALL  = 128'ha3b1bac656aa3350677d9197b27022dc;
  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT  = 128'h681edf34d206965e86b3e94f536e4246;
`ifdef SMS4_DEC_EN
  localparam bit DEC_ON = 1'b1;
`else
  localparam bit DEC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ks_get_key, ks_exp_run, ks_mode;
  logic [4:0]  ks_counter;
  logic [31:0] round_key = '0;

  int n_checks = 0;
  int n_errs = 0;

  sms4_round_core_if bus ();

  sms4_round_core dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ks_get_key (ks_get_key),
    .ks_exp_run (ks_exp_run),
    .ks_mode    (ks_mode),
    .ks_counter (ks_counter),
    .round_key  (round_key)
  );

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] v);
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++)
      r[8*j +: 8] = SBOX_TABLE[2047 - 8*int'(v[8*j +: 8]) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] t_data(input logic [31:0] v);
    logic [31:0] b = tau(v);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] v);
    logic [31:0] b = tau(v);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  // CK byte j of word i is (4i+j)*7 mod 256, byte 0 most significant.
  function automatic logic [31:0] ck_word(input int i);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++)
      w = {w[23:0], 8'(((4*i + j) * 7) % 256)};
    return w;
  endfunction

  function automatic logic [31:0] fk_word(input int i);
    return FK_ALL[127 - 32*i -: 32];
  endfunction

  // Whole-block SMS4 reference: full key schedule, then 32 rounds.
  function automatic logic [127:0] ref_sm4(input logic [127:0] key, input logic [127:0] blk,
                                           input bit d);
    logic [31:0] k [36];
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127 - 32*i -: 32] ^ fk_word(i);
      x[i] = blk[127 - 32*i -: 32];
    end
    for (int i = 0; i < 32; i++)
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i));
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ t_data(x[i+1] ^ x[i+2] ^ x[i+3] ^ (d ? k[35-i] : k[i+4]));
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- behavioural key-expansion block ----------------
  logic [127:0] tb_key = '0;
  logic [127:0] kb_reg = '0;
  logic [31:0]  kb_fwd, kb_rev;
  assign kb_fwd = kb_reg[127:96] ^ t_key(kb_reg[95:64] ^ kb_reg[63:32] ^ kb_reg[31:0]
                                         ^ ck_word(int'(ks_counter)));
  assign kb_rev = kb_reg[31:0] ^ t_key(kb_reg[127:96] ^ kb_reg[95:64] ^ kb_reg[63:32]
                                       ^ ck_word(int'(ks_counter)));

  always @(posedge clk) begin
    if (ks_get_key) begin
      kb_reg <= tb_key ^ FK_ALL;
    end else if (ks_exp_run) begin
      if (ks_mode) begin
        kb_reg    <= {kb_reg[95:0], kb_fwd};
        round_key <= kb_fwd;
      end else begin
        kb_reg    <= {kb_rev, kb_reg[127:32]};
        round_key <= kb_reg[31:0];
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".din_ready"},  128'(bus.din_ready),  128'd1);
    check({tag, ".dout"},       bus.dout,             128'd0);
    check({tag, ".dout_valid"}, 128'(bus.dout_valid), 128'd0);
    check({tag, ".busy"},       128'(bus.busy),       128'd0);
    check({tag, ".ks_get_key"}, 128'(ks_get_key),     128'd0);
    check({tag, ".ks_exp_run"}, 128'(ks_exp_run),     128'd0);
    check({tag, ".ks_mode"},    128'(ks_mode),        128'd1);
    check({tag, ".ks_counter"}, 128'(ks_counter),     128'd0);
  endtask

  // One block: handshake, per-cycle control trace, latency, result, optional back-pressure.
  task automatic run_block(input string name, input logic [127:0] key, input logic [127:0] blk,
                           input bit d, input logic [127:0] expv, input int lat,
                           input bit noise, input int hold);
    int cyc, gk_cnt, er_cnt, trace_bad, first_bad, bad_hold, e_ctr;
    bit de, e_gk, e_er, e_md;
    logic [127:0] held;
    de = DEC_ON && d;
    gk_cnt = 0; er_cnt = 0; trace_bad = 0; first_bad = -1; bad_hold = 0;
    tb_key = key;
    @(negedge clk);
    check({name, ".din_ready_idle"}, 128'(bus.din_ready), 128'd1);
    bus.din = blk; bus.dec = d; bus.din_valid = 1'b1; bus.dout_ready = (hold == 0);
    @(negedge clk);
    cyc = 1;
    bus.din_valid = 1'b0;
    while (bus.dout_valid !== 1'b1 && cyc < 200) begin
      e_gk = (cyc == 1);
      e_er = 1'b0; e_md = 1'b1; e_ctr = 0;
      if (cyc >= 2 && cyc <= 33) begin
        e_er = 1'b1; e_ctr = cyc - 2;
      end else if (de && cyc >= 34 && cyc <= 65) begin
        e_er = 1'b1; e_md = 1'b0; e_ctr = 65 - cyc;
      end
      if (ks_get_key !== e_gk || ks_exp_run !== e_er || ks_mode !== e_md ||
          ks_counter !== 5'(e_ctr) || bus.busy !== 1'b1 || bus.din_ready !== 1'b0) begin
        trace_bad++;
        if (first_bad < 0) first_bad = cyc;
      end
      gk_cnt += int'(ks_get_key);
      er_cnt += int'(ks_exp_run);
      if (noise) begin
        bus.din_valid = 1'($urandom_range(0, 1));
        bus.din = {$urandom, $urandom, $urandom, $urandom};
        bus.dec = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    bus.din_valid = 1'b0;
    bus.dec = 1'b0;
    check({name, ".latency"},    128'(cyc),       128'(lat));
    check({name, ".dout"},       bus.dout,        expv);
    check({name, ".ctrl_trace"}, 128'(trace_bad), 128'd0);
    check({name, ".get_key_n"},  128'(gk_cnt),    128'd1);
    check({name, ".exp_run_n"},  128'(er_cnt),    de ? 128'd64 : 128'd32);
    if (hold > 0) begin
      held = bus.dout;
      repeat (hold) begin
        @(negedge clk);
        if (bus.dout !== held || bus.dout_valid !== 1'b1 || bus.din_ready !== 1'b0)
          bad_hold++;
      end
      check({name, ".hold_stable"}, 128'(bad_hold), 128'd0);
      bus.dout_ready = 1'b1;
    end
    @(negedge clk);
    check({name, ".dout_valid_fall"}, 128'(bus.dout_valid), 128'd0);
    check({name, ".din_ready_back"},  128'(bus.din_ready),  128'd1);
    $display("txn %s: din=%h dec=%0d dout=%h latency=%0d trace_first_bad=%0d",
             name, blk, d, held_or(bus.dout), cyc, first_bad);
  endtask

  function automatic logic [127:0] held_or(input logic [127:0] v);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] blk;
    bit           dec;
    logic [127:0] expv;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [127:0] rk, rb;
    bit rd;
    bus.din = '0; bus.din_valid = 1'b0; bus.dec = 1'b0; bus.dout_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    vecs[0] = '{STD_KEY, STD_KEY, 1'b0, STD_CT, 35};
    if (DEC_ON) vecs[1] = '{STD_KEY, STD_CT, 1'b1, STD_KEY, 67};
    else        vecs[1] = '{STD_KEY, STD_CT, 1'b1, ref_sm4(STD_KEY, STD_CT, 1'b0), 35};
    for (int i = 2; i < 6; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      vecs[i] = '{rk, rb, rd, ref_sm4(rk, rb, DEC_ON && rd), (DEC_ON && rd) ? 67 : 35};
    end

    for (int i = 0; i < 6; i++)
      run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].blk, vecs[i].dec,
                vecs[i].expv, vecs[i].lat, 1'b0, 0);

    // Back-pressure: result held for 10 cycles with dout_ready low.
    run_block("backpressure", STD_KEY, STD_KEY, 1'b0, STD_CT, 35, 1'b0, 10);

    // New blocks offered while busy must be ignored.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run_block("busy_noise", rk, rb, 1'b0, ref_sm4(rk, rb, 1'b0), 35, 1'b1, 0);

    // Reset in the middle of RUN (rcnt = 10 is cycle 12).
    tb_key = STD_KEY;
    @(negedge clk);
    bus.din = STD_KEY; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    bus.din_valid = 1'b0;
    while (cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("midrun.ks_counter", 128'(ks_counter), 128'd10);
    check("midrun.busy",       128'(bus.busy),   128'd1);
    reset = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    @(negedge clk);
    reset = 1'b1;
    $display("txn midrun_reset: reset applied at cycle %0d", cyc);
    run_block("post_reset", STD_KEY, STD_KEY, 1'b0, STD_CT, 35, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
